mos6502s_status_stack: RTL and testbench

//  Parametrised processor status register with per-bit write enables and a hardware context

---
 rtl/mos6502s_pkg.sv | 23 ++
 rtl/mos6502s_status_lifo.sv | 94 +++++++++
 rtl/mos6502s_status_stack.sv | 99 +++++++++
 tb/tb_mos6502s_status_stack.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mos6502s_pkg.sv
// Shared definitions for the mos6502s datapath: flag bit positions, status word type
// and the default reset / forced-one / load_all-cleared masks.
package mos6502s_pkg;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_U = 5;
    localparam int FLAG_B = 4;
    localparam int FLAG_D = 3;
    localparam int FLAG_I = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam int STATUS_W = 8;

    typedef logic [STATUS_W-1:0] status_t;

    // U always reads as one; B only exists in pushed copies, never in a PLP-loaded p
    localparam status_t FORCE1_MASK_DEF = status_t'(1 << FLAG_U);
    localparam status_t ALLCLR_MASK_DEF = status_t'(1 << FLAG_B);
    localparam status_t RESET_VAL_DEF   = status_t'((1 << FLAG_U) | (1 << FLAG_I));

endpackage

// File: rtl/mos6502s_status_lifo.sv
// Circular context LIFO for saved status words. Registered top/depth/full/empty;
// overwrite_en selects whether a push into a full stack drops the oldest entry or is rejected.
module mos6502s_status_lifo
    import mos6502s_pkg::*;
#(
    parameter int W     = STATUS_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    input  logic                       overwrite_en,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic [W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [DEPTH_W-1:0] depth_reg, depth_next;
    logic [W-1:0]       top_reg, top_next;
    logic               full_reg, empty_reg;

    logic               swap, do_push, do_pop, wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic [W-1:0]       below_top;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] v);
        return (v == '0) ? PTR_W'(DEPTH - 1) : v - 1'b1;
    endfunction

    // ptr_reg is the next free slot, so the top lives at ptr-1 and the entry beneath it at ptr-2
    assign swap      = push && pop && !empty_reg;
    assign do_push   = push && !swap && (!full_reg || overwrite_en);
    assign do_pop    = pop && !push && !empty_reg;
    assign wr_en     = swap || do_push;
    assign wr_idx    = swap ? ptr_dec(ptr_reg) : ptr_reg;
    assign below_top = mem[ptr_dec(ptr_dec(ptr_reg))];

    always_comb begin
        ptr_next   = ptr_reg;
        depth_next = depth_reg;
        top_next   = top_reg;
        if (do_push) begin
            ptr_next   = ptr_inc(ptr_reg);
            depth_next = full_reg ? depth_reg : depth_reg + 1'b1;
            top_next   = push_data;
        end else if (swap) begin
            top_next   = push_data;
        end else if (do_pop) begin
            ptr_next   = ptr_dec(ptr_reg);
            depth_next = depth_reg - 1'b1;
            top_next   = (depth_reg > DEPTH_W'(1)) ? below_top : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            depth_reg <= '0;
            top_reg   <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            ptr_reg   <= ptr_next;
            depth_reg <= depth_next;
            top_reg   <= top_next;
            full_reg  <= (depth_next == DEPTH_W'(DEPTH));
            empty_reg <= (depth_next == '0);
        end
    end

    assign top   = top_reg;
    assign depth = depth_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/mos6502s_status_stack.sv
// Processor status register with per-bit loads and a hardware context LIFO for interrupts.
// Define MOS6502S_STATUS_STACK_ERR_EN to reject overflow and flag stack errors in err.
module mos6502s_status_stack
    import mos6502s_pkg::*;
#(
    parameter int                FLAG_W      = STATUS_W,
    parameter int                STACK_DEPTH = 4,
    parameter logic [FLAG_W-1:0] RESET_VAL   = FLAG_W'(RESET_VAL_DEF),
    parameter logic [FLAG_W-1:0] FORCE1_MASK = FLAG_W'(FORCE1_MASK_DEF),
    parameter logic [FLAG_W-1:0] ALLCLR_MASK = FLAG_W'(ALLCLR_MASK_DEF)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLAG_W-1:0]                load_mask,
    input  logic [FLAG_W-1:0]                bit_in,
    input  logic                             load_all,
    input  logic [FLAG_W-1:0]                all_in,
    input  logic                             push,
    input  logic                             pop,
    output logic [FLAG_W-1:0]                p,
    output logic [FLAG_W-1:0]                top,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             full,
    output logic                             empty,
    output logic                             err
);

    logic [FLAG_W-1:0] p_reg, p_next;
    logic [FLAG_W-1:0] masked_p;
    logic              lifo_full, lifo_empty;
    logic              overwrite_en;

    generate
        for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag_mux
            assign masked_p[gi] = load_mask[gi] ? bit_in[gi] : p_reg[gi];
        end
    endgenerate

    // A successful pop (alone or as a swap) wins over any load in the same cycle
    always_comb begin
        p_next = p_reg;
        if (pop && !lifo_empty) begin
            p_next = top | FORCE1_MASK;
        end else if (load_all) begin
            p_next = (all_in | FORCE1_MASK) & ~ALLCLR_MASK;
        end else if (|load_mask) begin
            p_next = masked_p | FORCE1_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg <= RESET_VAL;
        end else begin
            p_reg <= p_next;
        end
    end

`ifdef MOS6502S_STATUS_STACK_ERR_EN
    logic err_reg;

    assign overwrite_en = 1'b0;

    // A full stack with push&pop is a swap, not an overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((push && lifo_full && !pop) || (pop && lifo_empty)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign overwrite_en = 1'b1;
    assign err          = 1'b0;
`endif

    mos6502s_status_lifo #(
        .W     (FLAG_W),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .push_data    (p_reg),
        .overwrite_en (overwrite_en),
        .top          (top),
        .depth        (depth),
        .full         (lifo_full),
        .empty        (lifo_empty)
    );

    assign p     = p_reg;
    assign full  = lifo_full;
    assign empty = lifo_empty;

endmodule

// File: tb/tb_mos6502s_status_stack.sv
// Scoreboard bench for mos6502s_status_stack: the driver queues hand-computed expectations,
// a negedge monitor pops and compares one transaction per cycle.
module tb_mos6502s_status_stack;

`ifdef MOS6502S_STATUS_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] load_mask;
    logic [7:0] bit_in;
    logic       load_all;
    logic [7:0] all_in;
    logic       push;
    logic       pop;
    logic [7:0] p;
    logic [7:0] top;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err;

    typedef struct {
        string      name;
        logic [7:0] p;
        logic [7:0] top;
        logic [2:0] depth;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    mos6502s_status_stack dut (
        .clk       (clk),
        .rst       (rst),
        .load_mask (load_mask),
        .bit_in    (bit_in),
        .load_all  (load_all),
        .all_in    (all_in),
        .push      (push),
        .pop       (pop),
        .p         (p),
        .top       (top),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input string field,
                         input logic [7:0] act, input logic [7:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s.%s: got %02h, expected %02h", name, field, act, req);
        end
    endtask

    always begin
        @(negedge clk);
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            $display("txn %-12s p=%02h top=%02h depth=%0d full=%0b empty=%0b err=%0b",
                     mon_e.name, p, top, depth, full, empty, err);
            check(mon_e.name, "p",     p,           mon_e.p);
            check(mon_e.name, "top",   top,         mon_e.top);
            check(mon_e.name, "depth", 8'(depth),   8'(mon_e.depth));
            check(mon_e.name, "full",  8'(full),    8'(mon_e.depth == 3'd4));
            check(mon_e.name, "empty", 8'(empty),   8'(mon_e.depth == 3'd0));
            check(mon_e.name, "err",   8'(err),     8'(mon_e.err));
        end
    end

    task automatic cyc(input bit r, input logic [7:0] lm, input logic [7:0] bi,
                       input bit la, input logic [7:0] ai, input bit pu, input bit po,
                       input logic [7:0] ep, input logic [7:0] et, input logic [2:0] ed,
                       input bit ee, input string nm);
        exp_t e;
        @(negedge clk);
        rst       = r;
        load_mask = lm;
        bit_in    = bi;
        load_all  = la;
        all_in    = ai;
        push      = pu;
        pop       = po;
        @(posedge clk);
        e.name  = nm;
        e.p     = ep;
        e.top   = et;
        e.depth = ed;
        e.err   = ee;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [7:0] pv;
        rst = 1'b1; load_mask = '0; bit_in = '0; load_all = 1'b0;
        all_in = '0; push = 1'b0; pop = 1'b0;
        pv = ERR_EN ? 8'hA3 : 8'hE1;

        //   rst lm     bi     la ai     pu po  p      top    d  err     name
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h24, 8'h00, 0, 0,      "reset");
        cyc(0, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 8'hEF, 8'h00, 0, 0,      "ldall_ff");
        cyc(0, 8'h00, 8'h00, 1, 8'h20, 0, 0, 8'h20, 8'h00, 0, 0,      "ldall_20");
        cyc(0, 8'h04, 8'h04, 0, 8'h00, 1, 0, 8'h24, 8'h20, 1, 0,      "mask_push");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h20, 8'h00, 0, 0,      "pop_back");
        cyc(0, 8'h00, 8'h00, 1, 8'hA1, 0, 0, 8'hA1, 8'h00, 0, 0,      "ldall_a1");
        cyc(0, 8'h00, 8'h00, 1, 8'hA2, 1, 0, 8'hA2, 8'hA1, 1, 0,      "push_a1");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'hA2, 8'hA2, 2, 0,      "push_a2");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'hA2, 8'hA1, 1, 0,      "pop_a2");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'hA1, 8'h00, 0, 0,      "pop_a1");
        cyc(0, 8'h00, 8'h00, 1, 8'h61, 0, 0, 8'h61, 8'h00, 0, 0,      "ldall_61");
        cyc(0, 8'h00, 8'h00, 1, 8'h23, 1, 0, 8'h23, 8'h61, 1, 0,      "push_61");
        cyc(0, 8'h00, 8'h00, 1, 8'h55, 1, 1, 8'h61, 8'h23, 1, 0,      "swap");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h23, 8'h00, 0, 0,      "pop_23");
        cyc(0, 8'h00, 8'h00, 1, 8'h41, 1, 0, 8'h61, 8'h23, 1, 0,      "fill1");
        cyc(0, 8'h00, 8'h00, 1, 8'h42, 1, 0, 8'h62, 8'h61, 2, 0,      "fill2");
        cyc(0, 8'h00, 8'h00, 1, 8'h43, 1, 0, 8'h63, 8'h62, 3, 0,      "fill3");
        cyc(0, 8'h00, 8'h00, 1, 8'h44, 1, 0, 8'h64, 8'h63, 4, 0,      "fill4");
        cyc(0, 8'h00, 8'h00, 1, 8'h45, 1, 0, 8'h65,
            ERR_EN ? 8'h63 : 8'h64, 4, ERR_EN, "push_full");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, ERR_EN ? 8'h63 : 8'h64,
            ERR_EN ? 8'h62 : 8'h63, 3, ERR_EN, "drain1");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, ERR_EN ? 8'h62 : 8'h63,
            ERR_EN ? 8'h61 : 8'h62, 2, ERR_EN, "drain2");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, ERR_EN ? 8'h61 : 8'h62,
            ERR_EN ? 8'h23 : 8'h61, 1, ERR_EN, "drain3");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, ERR_EN ? 8'h23 : 8'h61,
            8'h00, 0, ERR_EN, "drain4");
        cyc(0, 8'h80, 8'h80, 0, 8'h00, 0, 1, pv, 8'h00, 0, ERR_EN,    "pop_empty");
        cyc(0, 8'h00, 8'h00, 1, 8'h01, 1, 0, 8'h21, pv, 1, ERR_EN,    "s6_push1");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h21, 8'h21, 2, ERR_EN, "s6_push2");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h21, 8'h21, 3, ERR_EN, "s6_push3");
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h24, 8'h00, 0, 0,      "rst_pop");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h24, 8'h00, 0, 0,      "idle");
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h24, 8'h24, 1, ERR_EN, "pushpop_mt");

        @(negedge clk);
        push = 1'b0; pop = 1'b0; load_all = 1'b0; load_mask = '0;
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d transactions left, expected 0", sb_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
